data_mem_banked: RTL and testbench

//   Parametrised single-port data memory with a request/ready handshake.

---
 rtl/data_mem_banked.sv | 111 +++++++++++
 tb/tb_data_mem_banked.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_banked.sv
// rtl/data_mem_banked.sv - single-port data memory with byte enables, registered read and reset-time clear
// A CLEAR/IDLE sequencer zeroes the array after reset; requests are accepted only while idle.
module data_mem_banked #(
  parameter int    DATA_W         = 16,
  parameter int    ADDR_W         = 16,
  parameter int    DEPTH          = 8,
  parameter string INIT_FILE      = "",
  parameter int    CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W/8-1:0]   mem_be,
  output logic                  mem_ready,
  output logic                  mem_rvalid,
  output logic [DATA_W-1:0]     mem_rdata,
  output logic                  mem_err,
  output logic                  mem_busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int BE_W  = DATA_W / 8;

  typedef enum logic {S_CLEAR, S_IDLE} state_e;
  localparam state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              rvalid_q, err_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              accept, in_range, clr_en;
  logic [IDX_W-1:0]  idx;

  assign accept   = mem_req && ready_q;
  assign in_range = {1'b0, mem_addr} < (ADDR_W+1)'(DEPTH);
  assign idx      = mem_addr[IDX_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_en  = 1'b0;
    case (state_q)
      S_CLEAR: begin
        // Gated by rst_n so holding reset never disturbs the array.
        clr_en = rst_n;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d == S_CLEAR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q  <= 1'b0;
      busy_q   <= (CLEAR_ON_RESET != 0);
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      rvalid_q <= accept && !mem_we;
      err_q    <= accept && !in_range;
      if (accept && !mem_we) begin
        rdata_q <= in_range ? mem_q[idx] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem_q[cnt_q] <= '0;
    end else if (accept && mem_we && in_range) begin
      for (int i = 0; i < BE_W; i++) begin
        if (mem_be[i]) begin
          mem_q[idx][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

  assign mem_ready  = ready_q;
  assign mem_busy   = busy_q;
  assign mem_rvalid = rvalid_q;
  assign mem_rdata  = rdata_q;
  assign mem_err    = err_q;

endmodule

// File: tb/tb_data_mem_banked.sv
// tb/tb_data_mem_banked.sv - scoreboard bench for data_mem_banked with a queue-based reference model
module tb_data_mem_banked;

  localparam int DW  = 16;
  localparam int AW  = 16;
  localparam int DEP = 8;
  localparam int BEW = DW / 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            mem_req = 1'b0;
  logic            mem_we = 1'b0;
  logic [AW-1:0]   mem_addr = '0;
  logic [DW-1:0]   mem_wdata = '0;
  logic [BEW-1:0]  mem_be = '0;
  logic            mem_ready, mem_rvalid, mem_err, mem_busy;
  logic [DW-1:0]   mem_rdata;

  data_mem_banked #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .INIT_FILE(""), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_err(mem_err), .mem_busy(mem_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          err;
    logic          rvalid;
    logic [DW-1:0] rdata;
  } resp_t;

  resp_t         exp_q[$];
  resp_t         mon_r;
  logic [DW-1:0] model [DEP];
  logic          tb_ready = 1'b0;
  int            pass_cnt = 0;
  int            total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Drives one cycle of stimulus; the reference decides acceptance from its own ready flag.
  task automatic issue(input logic req, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BEW-1:0] be);
    resp_t r;
    mem_req = req; mem_we = we; mem_addr = a; mem_wdata = d; mem_be = be;
    if (req && tb_ready) begin
      if (we) begin
        if (a < DEP) begin
          for (int i = 0; i < BEW; i++)
            if (be[i]) model[int'(a)][8*i +: 8] = d[8*i +: 8];
        end else begin
          r.err = 1'b1; r.rvalid = 1'b0; r.rdata = '0;
          exp_q.push_back(r);
        end
      end else begin
        r.rvalid = 1'b1;
        r.err    = (a >= DEP);
        r.rdata  = (a < DEP) ? model[int'(a)] : '0;
        exp_q.push_back(r);
      end
    end
    @(posedge clk); #1;
    mem_req = 1'b0; mem_we = 1'b0;
  endtask

  task automatic release_and_clear(input bit inject);
    int n;
    n = 0;
    rst_n = 1'b1;
    tb_ready = 1'b0;
    while (mem_busy === 1'b1 && n < 20) begin
      check("ready_low_in_clear", mem_ready, 1'b0);
      n++;
      if (inject && n == 2) begin
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'd2; mem_wdata = 16'h5555; mem_be = 2'b11;
      end else begin
        mem_req = 1'b0; mem_we = 1'b0;
      end
      @(posedge clk); #1;
    end
    mem_req = 1'b0; mem_we = 1'b0;
    check("clear_len", n, 8);
    check("ready_after_clear", mem_ready, 1'b1);
    for (int i = 0; i < DEP; i++) model[i] = '0;
    tb_ready = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n && (mem_rvalid || mem_err)) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_resp: rvalid=%0b err=%0b required no response at %0t",
                 mem_rvalid, mem_err, $time);
      end else begin
        mon_r = exp_q.pop_front();
        check("resp_rvalid", mem_rvalid, mon_r.rvalid);
        check("resp_err", mem_err, mon_r.err);
        if (mon_r.rvalid) check("resp_rdata", mem_rdata, mon_r.rdata);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", mem_ready, 1'b0);
    check("rst_busy", mem_busy, 1'b1);
    check("rst_rvalid", mem_rvalid, 1'b0);
    check("rst_err", mem_err, 1'b0);
    check("rst_rdata", mem_rdata, 16'h0);

    // Clear length, then every word reads zero with rvalid on each cycle.
    release_and_clear(1'b0);
    for (int i = 0; i < DEP; i++) begin
      issue(1'b1, 1'b0, AW'(i), '0, '0);
      check("rd_rvalid_latency", mem_rvalid, 1'b1);
    end

    // Byte-enable merge.
    issue(1'b1, 1'b1, 16'd3, 16'hBEEF, 2'b11);
    issue(1'b1, 1'b0, 16'd3, '0, '0);
    issue(1'b1, 1'b1, 16'd3, 16'h1234, 2'b01);
    issue(1'b1, 1'b0, 16'd3, '0, '0);
    issue(1'b1, 1'b1, 16'd3, 16'h77AA, 2'b10);
    issue(1'b1, 1'b0, 16'd3, '0, '0);

    // Fill then back-to-back reads.
    for (int i = 0; i < DEP; i++) issue(1'b1, 1'b1, AW'(i), DW'(16'h1000 + i), 2'b11);
    for (int i = 0; i < DEP; i++) begin
      issue(1'b1, 1'b0, AW'(i), '0, '0);
      check("b2b_rvalid", mem_rvalid, 1'b1);
    end
    issue(1'b0, 1'b0, '0, '0, '0);
    check("rvalid_drops", mem_rvalid, 1'b0);
    check("rdata_holds", mem_rdata, 16'h1007);

    // Out-of-range write and read.
    issue(1'b1, 1'b1, 16'd8, 16'hAAAA, 2'b11);
    issue(1'b0, 1'b0, '0, '0, '0);
    check("err_pulse_len", mem_err, 1'b0);
    issue(1'b1, 1'b0, 16'd0, '0, '0);
    issue(1'b1, 1'b0, 16'h0010, '0, '0);
    issue(1'b1, 1'b0, 16'hFFFF, '0, '0);
    issue(1'b1, 1'b0, 16'd5, '0, '0);
    issue(1'b0, 1'b0, '0, '0, '0);

    // Reset mid-clear: outputs drop at once and the clear restarts in full.
    rst_n = 1'b0;
    tb_ready = 1'b0;
    #1;
    check("async_rst_rdata", mem_rdata, 16'h0);
    check("async_rst_ready", mem_ready, 1'b0);
    check("async_rst_busy", mem_busy, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("mid_clear_busy", mem_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_clear_rst_ready", mem_ready, 1'b0);
    check("mid_clear_rst_rvalid", mem_rvalid, 1'b0);
    @(posedge clk); #1;

    // Full clear with an ignored write request in the middle of it.
    release_and_clear(1'b1);
    for (int i = 0; i < DEP; i++) issue(1'b1, 1'b0, AW'(i), '0, '0);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      issue(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            AW'($urandom_range(0, 11)), DW'($urandom), BEW'($urandom_range(0, 3)));
    end
    repeat (3) issue(1'b0, 1'b0, '0, '0, '0);
    check("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
